// File: rtl/rx_packet_parser.sv
// rx_packet_parser: SOF/CMD/ARG_H/ARG_L/CHK byte-frame parser with a one-packet holding register.
// Define RX_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module rx_packet_parser #(
  parameter logic [7:0] SOF = 8'hA5,
  parameter int TIMEOUT_CYCLES = 104_200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        parity_ok,
  input  logic        pkt_ack,
  output logic        pkt_valid,
  output logic [7:0]  pkt_cmd,
  output logic [15:0] pkt_arg,
  output logic        err_parity,
  output logic        err_checksum,
  output logic        err_overrun,
  output logic        err_timeout,
  output logic [2:0]  db_estado
);
  typedef enum logic [2:0] {
    ESPERA_SOF   = 3'd0,
    RECEBE_CMD   = 3'd1,
    RECEBE_ARG_H = 3'd2,
    RECEBE_ARG_L = 3'd3,
    RECEBE_CHK   = 3'd4
  } state_t;
  state_t state_q, state_d;
  logic vprev_q;
  logic [7:0] cmd_q, cmd_d, argh_q, argh_d, argl_q, argl_d, pkt_cmd_q, pkt_cmd_d;
  logic [15:0] pkt_arg_q, pkt_arg_d;
  logic pkt_valid_q, pkt_valid_d;
  logic err_par_q, err_par_d, err_chk_q, err_chk_d, err_ovr_q, err_ovr_d, err_to_q, err_to_d;
  logic ev, done, timeout;
  assign ev = byte_valid & ~vprev_q;
`ifdef RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = state_q != ESPERA_SOF && !ev && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d = (state_q == ESPERA_SOF || ev || timeout) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = timeout ? ESPERA_SOF : state_q;
    cmd_d = cmd_q;
    argh_d = argh_q;
    argl_d = argl_q;
    pkt_valid_d = pkt_valid_q;
    pkt_cmd_d = pkt_cmd_q;
    pkt_arg_d = pkt_arg_q;
    err_par_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovr_d = 1'b0;
    err_to_d = timeout;
    done = 1'b0;
    if (ev && !parity_ok) begin
      err_par_d = 1'b1;
      state_d = ESPERA_SOF;
    end else if (ev) begin
      case (state_q)
        ESPERA_SOF:   state_d = byte_data == SOF ? RECEBE_CMD : ESPERA_SOF;
        RECEBE_CMD:   begin cmd_d = byte_data; state_d = RECEBE_ARG_H; end
        RECEBE_ARG_H: begin argh_d = byte_data; state_d = RECEBE_ARG_L; end
        RECEBE_ARG_L: begin argl_d = byte_data; state_d = RECEBE_CHK; end
        default: begin
          state_d = ESPERA_SOF;
          done = byte_data == (cmd_q ^ argh_q ^ argl_q);
          err_chk_d = ~done;
        end
      endcase
    end
    // an ack in the completion cycle frees the register for the new frame
    if (done && (!pkt_valid_q || pkt_ack)) begin
      pkt_valid_d = 1'b1;
      pkt_cmd_d = cmd_q;
      pkt_arg_d = {argh_q, argl_q};
    end else if (done) begin
      err_ovr_d = 1'b1;
    end else if (pkt_ack) begin
      pkt_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ESPERA_SOF;
      vprev_q <= 1'b0;
      cmd_q <= '0;
      argh_q <= '0;
      argl_q <= '0;
      pkt_valid_q <= 1'b0;
      pkt_cmd_q <= '0;
      pkt_arg_q <= '0;
      err_par_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovr_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vprev_q <= byte_valid;
      cmd_q <= cmd_d;
      argh_q <= argh_d;
      argl_q <= argl_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_cmd_q <= pkt_cmd_d;
      pkt_arg_q <= pkt_arg_d;
      err_par_q <= err_par_d;
      err_chk_q <= err_chk_d;
      err_ovr_q <= err_ovr_d;
      err_to_q <= err_to_d;
    end
  end
  assign pkt_valid = pkt_valid_q;
  assign pkt_cmd = pkt_cmd_q;
  assign pkt_arg = pkt_arg_q;
  assign err_parity = err_par_q;
  assign err_checksum = err_chk_q;
  assign err_overrun = err_ovr_q;
  assign err_timeout = err_to_q;
  assign db_estado = state_q;
endmodule

// File: tb/tb_rx_packet_parser.sv
// tb_rx_packet_parser: scoreboard bench for rx_packet_parser; the timeout scenario follows RX_TIMEOUT_EN.
module tb_rx_packet_parser;
  logic clock = 1'b0, reset = 1'b1, byte_valid = 1'b0, parity_ok = 1'b1, pkt_ack = 1'b0;
  logic [7:0] byte_data = '0;
  logic pkt_valid, err_parity, err_checksum, err_overrun, err_timeout;
  logic [7:0] pkt_cmd;
  logic [15:0] pkt_arg;
  logic [2:0] db_estado;
  int checks = 0, errors = 0;
  int n_par = 0, n_chk = 0, n_ovr = 0, n_to = 0;
  logic [23:0] exp_q[$];
  logic [23:0] got_pkt, exp_pkt, prev_pkt = '0;
  logic prev_valid = 1'b0;
  logic [3:0] err_v, prev_err = '0;

  rx_packet_parser #(.SOF(8'hA5), .TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .parity_ok(parity_ok), .pkt_ack(pkt_ack), .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd),
    .pkt_arg(pkt_arg), .err_parity(err_parity), .err_checksum(err_checksum),
    .err_overrun(err_overrun), .err_timeout(err_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // monitor: error pulse counting/shape and scoreboard pop on every packet load
  always @(negedge clock) begin
    err_v = {err_parity, err_checksum, err_overrun, err_timeout};
    n_par += int'(err_v[3]);
    n_chk += int'(err_v[2]);
    n_ovr += int'(err_v[1]);
    n_to += int'(err_v[0]);
    if ($countones(err_v) > 1) begin
      errors++;
      $display("FAIL err_onehot: got %b, need at most one bit set", err_v);
    end
    if ((err_v & prev_err) != 4'b0) begin
      errors++;
      $display("FAIL err_pulse_width: got %b after %b, need single-cycle pulses", err_v, prev_err);
    end
    got_pkt = {pkt_cmd, pkt_arg};
    if (pkt_valid && (!prev_valid || got_pkt != prev_pkt)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pkt: got %h, need no packet", got_pkt);
      end else begin
        exp_pkt = exp_q.pop_front();
        if (got_pkt !== exp_pkt) begin
          errors++;
          $display("FAIL pkt_data: got %h, need %h", got_pkt, exp_pkt);
        end
      end
    end
    prev_err = err_v;
    prev_valid = pkt_valid;
    prev_pkt = got_pkt;
  end

  task automatic send_byte(input logic [7:0] b, input logic p = 1'b1, input int hold = 1);
    @(posedge clock); #1;
    byte_valid = 1'b1; byte_data = b; parity_ok = p;
    repeat (hold) @(posedge clock);
    #1 byte_valid = 1'b0; parity_ok = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic bad = 1'b0);
    send_byte(8'hA5); send_byte(c); send_byte(h); send_byte(l);
    send_byte(c ^ h ^ l ^ {7'b0, bad});
  endtask

  task automatic ack_pkt();
    @(posedge clock); #1 pkt_ack = 1'b1;
    @(posedge clock); #1 pkt_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({pkt_valid, pkt_cmd, pkt_arg, err_parity, err_checksum, err_overrun, err_timeout, db_estado} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b cmd=%h arg=%h st=%0d, need all 0", pkt_valid, pkt_cmd, pkt_arg, db_estado);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_good_frame();
    int s = n_par + n_chk + n_ovr + n_to;
    exp_q.push_back({8'h12, 16'h3456});
    send_byte(8'hA5, 1, 3); send_byte(8'h12, 1, 3); send_byte(8'h34, 1, 3); send_byte(8'h56, 1, 3);
    @(posedge clock); #1 byte_valid = 1'b1; byte_data = 8'h70;
    @(negedge clock);
    checks++;
    if (pkt_valid !== 1'b0) begin errors++; $display("FAIL good_early: got pkt_valid=%b, need 0", pkt_valid); end
    @(negedge clock);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h12 || pkt_arg !== 16'h3456) begin
      errors++;
      $display("FAIL good_latency: got v=%b cmd=%h arg=%h, need 1/12/3456", pkt_valid, pkt_cmd, pkt_arg);
    end
    @(posedge clock); #1;
    @(posedge clock); #1 byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (db_estado !== 3'd0 || n_par + n_chk + n_ovr + n_to !== s) begin
      errors++;
      $display("FAIL good_clean: got st=%0d errs=%0d, need 0/%0d", db_estado, n_par + n_chk + n_ovr + n_to, s);
    end
    ack_pkt();
    @(negedge clock);
    checks++;
    if (pkt_valid !== 1'b0 || pkt_cmd !== 8'h12) begin
      errors++;
      $display("FAIL ack_clear: got v=%b cmd=%h, need 0/12", pkt_valid, pkt_cmd);
    end
  endtask

  task automatic test_checksum();
    int s = n_chk;
    send_frame(8'h12, 8'h34, 8'h56, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (n_chk !== s + 1 || pkt_valid !== 1'b0 || db_estado !== 3'd0) begin
      errors++;
      $display("FAIL checksum: got chk_pulses=%0d v=%b st=%0d, need %0d/0/0", n_chk - s, pkt_valid, db_estado, 1);
    end
  endtask

  task automatic test_parity();
    int s = n_par;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (n_par !== s + 1 || db_estado !== 3'd0) begin
      errors++;
      $display("FAIL parity_abort: got pulses=%0d st=%0d, need 1/0", n_par - s, db_estado);
    end
    send_byte(8'hA5, 1'b0); send_byte(8'h33);
    repeat (2) @(negedge clock);
    checks++;
    if (n_par !== s + 2 || db_estado !== 3'd0) begin
      errors++;
      $display("FAIL parity_idle: got pulses=%0d st=%0d, need 2/0", n_par - s, db_estado);
    end
    exp_q.push_back({8'h01, 16'h0203});
    send_frame(8'h01, 8'h02, 8'h03);
    repeat (2) @(negedge clock);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h01 || pkt_arg !== 16'h0203 || n_par !== s + 2) begin
      errors++;
      $display("FAIL parity_recover: got v=%b cmd=%h arg=%h, need 1/01/0203", pkt_valid, pkt_cmd, pkt_arg);
    end
    ack_pkt();
  endtask

  task automatic test_sof_data();
    exp_q.push_back({8'hA5, 16'hA500});
    send_frame(8'hA5, 8'hA5, 8'h00);
    @(negedge clock);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_cmd !== 8'hA5 || pkt_arg !== 16'hA500) begin
      errors++;
      $display("FAIL sof_as_data: got v=%b cmd=%h arg=%h, need 1/A5/A500", pkt_valid, pkt_cmd, pkt_arg);
    end
    ack_pkt();
  endtask

  task automatic test_back_to_back();
    int s = n_ovr;
    exp_q.push_back({8'h21, 16'h4321});
    send_frame(8'h21, 8'h43, 8'h21);
    send_frame(8'h5A, 8'hBE, 8'hEF);
    repeat (2) @(negedge clock);
    checks++;
    if (n_ovr !== s + 1 || pkt_valid !== 1'b1 || {pkt_cmd, pkt_arg} !== 24'h214321) begin
      errors++;
      $display("FAIL overrun: got pulses=%0d v=%b pkt=%h, need 1/1/214321", n_ovr - s, pkt_valid, {pkt_cmd, pkt_arg});
    end
    exp_q.push_back({8'h66, 16'h0102});
    send_byte(8'hA5); send_byte(8'h66); send_byte(8'h01); send_byte(8'h02);
    @(posedge clock); #1 byte_valid = 1'b1; byte_data = 8'h66 ^ 8'h01 ^ 8'h02; pkt_ack = 1'b1;
    @(posedge clock); #1 byte_valid = 1'b0; pkt_ack = 1'b0;
    @(negedge clock);
    checks++;
    if (pkt_valid !== 1'b1 || {pkt_cmd, pkt_arg} !== 24'h660102) begin
      errors++;
      $display("FAIL ack_reload: got v=%b pkt=%h, need 1/660102", pkt_valid, {pkt_cmd, pkt_arg});
    end
    @(negedge clock);
    checks++;
    if (n_ovr !== s + 1) begin errors++; $display("FAIL ack_no_overrun: got pulses=%0d, need 1", n_ovr - s); end
    ack_pkt();
  endtask

  task automatic test_timeout();
    int s = n_to;
    int waited = 0;
    send_byte(8'hA5); send_byte(8'h12);
    @(negedge clock);
    checks++;
    if (db_estado !== 3'd2) begin errors++; $display("FAIL to_state: got st=%0d, need 2", db_estado); end
`ifdef RX_TIMEOUT_EN
    while (n_to == s && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (n_to !== s + 1 || waited < 18 || waited > 23 || db_estado !== 3'd0) begin
      errors++;
      $display("FAIL timeout: got pulses=%0d after %0d cycles st=%0d, need 1 after ~20, st 0", n_to - s, waited, db_estado);
    end
`else
    repeat (40) @(negedge clock);
    checks++;
    if (n_to !== s || db_estado !== 3'd2 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: got pulses=%0d st=%0d, need 0/2", n_to - s, db_estado);
    end
`endif
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s;
    exp_q.push_back({8'h11, 16'h2233});
    send_frame(8'h11, 8'h22, 8'h33);
    send_byte(8'hA5); send_byte(8'h44); send_byte(8'h55);
    @(negedge clock);
    checks++;
    if (db_estado !== 3'd3 || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got st=%0d v=%b, need 3/1", db_estado, pkt_valid);
    end
    s = n_par + n_chk + n_ovr + n_to;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({pkt_valid, pkt_cmd, pkt_arg, err_parity, err_checksum, err_overrun, err_timeout, db_estado} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b cmd=%h arg=%h st=%0d, need all 0", pkt_valid, pkt_cmd, pkt_arg, db_estado);
    end
    exp_q.push_back({8'h77, 16'h8899});
    send_frame(8'h77, 8'h88, 8'h99);
    repeat (2) @(negedge clock);
    checks++;
    if (pkt_valid !== 1'b1 || {pkt_cmd, pkt_arg} !== 24'h778899 || n_par + n_chk + n_ovr + n_to !== s) begin
      errors++;
      $display("FAIL post_reset: got v=%b pkt=%h errs=%0d, need 1/778899/0", pkt_valid, {pkt_cmd, pkt_arg}, n_par + n_chk + n_ovr + n_to - s);
    end
    ack_pkt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, need finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_checksum();
    test_parity();
    test_sof_data();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
